serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller. Sequences a single 1-bit mux-based full-adder cell over WIDTH cycles to add two WIDTH-bit operands LSB-first.
- Carry is held in a flip-flop between bit steps.
- Provides a start/busy/done handshake to the surrounding datapath, trading area for latency versus a ripple adder.

---
 rtl/serial_adder_ctrl_pkg.sv | 22 ++
 rtl/serial_adder_ctrl_fa_mux_cell.sv | 32 +++
 rtl/serial_adder_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl_pkg
// Description : Shared definitions for the bit-serial adder controller:
//               default operand width and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_ctrl_pkg;

  // Default operand/result width; legal range is 1..32.
  localparam int SAC_WIDTH_DEFAULT = 8;

  // Controller states. The encoding is fixed so that waveforms and any
  // external debug taps see stable values.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sac_state_e;

endpackage : serial_adder_ctrl_pkg
`default_nettype wire

// File: rtl/serial_adder_ctrl_fa_mux_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_mux_cell
// Description : Combinational 1-bit full adder built from two 4:1 muxes
//               selected by {b,a}. Sum data: c,~c,~c,c. Carry data: 0,c,c,1.
// Revision    : 1.0 - initial release
// ============================================================================
module fa_mux_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic [1:0] sel;
  assign sel = {b, a};

  // Two 4:1 muxes sharing one select; carry-in is the only data variable.
  always_comb begin
    s  = 1'b0;
    co = 1'b0;
    case (sel)
      2'b00: begin s = c;  co = 1'b0; end
      2'b01: begin s = ~c; co = c;    end
      2'b10: begin s = ~c; co = c;    end
      default: begin s = c; co = 1'b1; end
    endcase
  end

endmodule : fa_mux_cell
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. Streams two WIDTH-bit operands
//               LSB-first through a single mux-based full-adder cell, holding
//               the carry in a flop between bit steps. start/busy/done
//               handshake; sum/cout are registered and only change on entry
//               to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter  int WIDTH = SAC_WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sac_state_e       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q,  carry_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] res_next;

  // The single shared adder cell, fed from the low bits of the shifters.
  fa_mux_cell u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .c  (carry_q),
    .s  (fa_sum),
    .co (fa_carry)
  );

  // Result shifter input: the new sum bit enters at the MSB. A 1-bit result
  // has no upper bits to shift down, so it is just the cell output.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = fa_sum;
    end else begin : g_res_wn
      assign res_next = {fa_sum, res_sh_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and datapath update; start is only honoured when not busy.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_next;
        carry_d  = fa_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = res_next;
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Handshake outputs decode the registered state only.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl (WIDTH=8 and an
//               exhaustive WIDTH=4 instance). Expected results are queued
//               when an operation is started and compared on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  logic         start4;
  logic [3:0]   a4, b4;
  logic         cin4;
  logic         busy4, done4;
  logic [3:0]   sum4;
  logic         cout4;

  int checks = 0;
  int errors = 0;

  logic [W:0] sb[$];
  logic [4:0] sb4[$];
  logic [W:0] last_res;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (busy4 !== 1'b0 || sum4 !== 4'h0) begin errors++; $display("FAIL reset_w4 got busy=%b sum=%h exp 0/0", busy4, sum4); end
    last_res = '0;
  endtask

  // One isolated operation: checks busy/done timing, output stability and result.
  task automatic run_single(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    logic [W:0] exp;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    sb.push_back({1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc});
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      checks++; if (busy !== (k <= W)) begin errors++; $display("FAIL %s_busy k=%0d got=%b exp=%b", name, k, busy, (k <= W)); end
      checks++; if (done !== (k == W + 1)) begin errors++; $display("FAIL %s_done k=%0d got=%b exp=%b", name, k, done, (k == W + 1)); end
      if (k == W + 1) begin
        exp = sb.pop_front();
        last_res = exp;
      end
      checks++; if ({cout, sum} !== last_res) begin errors++; $display("FAIL %s_result k=%0d got=%h exp=%h", name, k, {cout, sum}, last_res); end
    end
  endtask

  task automatic test_basic();
    run_single("basic", 8'h35, 8'h4A, 1'b0);
  endtask

  task automatic test_carry();
    run_single("carry_ff01", 8'hFF, 8'h01, 1'b0);
    run_single("carry_ff00c", 8'hFF, 8'h00, 1'b1);
    run_single("carry_ffffc", 8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    sb.push_back(9'h046);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      checks++; if (busy !== (k <= W)) begin errors++; $display("FAIL ignore_busy k=%0d got=%b exp=%b", k, busy, (k <= W)); end
      if (done === 1'b1) begin
        ndone++;
        last_res = sb.pop_front();
      end
      checks++; if ({cout, sum} !== last_res) begin errors++; $display("FAIL ignore_result k=%0d got=%h exp=%h", k, {cout, sum}, last_res); end
      if (k == 3) begin a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1; end
      if (k == 4) start = 1'b0;
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (last_res !== 9'h046) begin errors++; $display("FAIL ignore_final got=%h exp=046", last_res); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    sb.push_back(9'h002);
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      checks++; if (busy !== ((k % 9) != 0)) begin errors++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy, ((k % 9) != 0)); end
      checks++; if (done !== ((k % 9) == 0)) begin errors++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done, ((k % 9) == 0)); end
      if ((k % 9) == 0) begin
        last_res = sb.pop_front();
        if (k < 27) sb.push_back(9'h002);
        else start = 1'b0;
      end
      checks++; if ({cout, sum} !== last_res) begin errors++; $display("FAIL b2b_result k=%0d got=%h exp=%h", k, {cout, sum}, last_res); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy k=%0d got=%b exp=1", k, busy); end
      if (k == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done_after got=%b exp=0", done); end
    checks++; if ({cout, sum} !== 9'h000) begin errors++; $display("FAIL rstmid_result got=%h exp=000", {cout, sum}); end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet k=%0d got busy=%b done=%b exp 0/0", k, busy, done); end
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [4:0] exp;
    bit seen;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          @(negedge clk);
          a4 = 4'(ai); b4 = 4'(bi); cin4 = ci[0]; start4 = 1'b1;
          sb4.push_back(5'(ai + bi + ci));
          seen = 1'b0;
          for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) start4 = 1'b0;
            if (done4 === 1'b1) seen = 1'b1;
          end
          checks++;
          if (!seen) begin
            errors++;
            $display("FAIL w4_timeout a=%h b=%h cin=%0d got=no_done exp=done", ai[3:0], bi[3:0], ci);
            void'(sb4.pop_front());
          end else begin
            exp = sb4.pop_front();
            if ({cout4, sum4} !== exp) begin
              errors++;
              $display("FAIL w4_sum a=%h b=%h cin=%0d got=%h exp=%h", ai[3:0], bi[3:0], ci, {cout4, sum4}, exp);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
`default_nettype wire
